// File: rtl/pingpong_xfer_buffer.sv
// Ping-pong transfer buffer: two DEPTH-word banks, one filled by the producer
// while the other is drained by the consumer, for a run of FRAMES bank fills.
// Handshake: DIN_VALID qualifies DATA_IN every cycle (no backpressure; words
// that find no free bank are dropped and flagged). EP_READ is honoured only
// when EP_READY is 1, and its word appears on DATA_OUT with DOUT_VALID one
// cycle later.
// Optional feature macro PP_OVF_CNT_EN adds the OVF_COUNT output.
module pingpong_xfer_buffer #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 256,
  parameter int FRAMES = 120
) (
  input  logic             CLK,
  input  logic             RST_BAR,
  input  logic             START,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic             DIN_VALID,
  input  logic             EP_READ,
  output logic [WIDTH-1:0] DATA_OUT,
  output logic             DOUT_VALID,
  output logic             EP_READY,
  output logic             BANK_SEL,
  output logic [15:0]      FRAME_CNT,
  output logic             OVERFLOW,
  output logic             DONE
`ifdef PP_OVF_CNT_EN
  ,
  output logic [15:0]      OVF_COUNT
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FINISH} run_state_e;
  typedef enum logic [1:0] {BK_EMPTY, BK_FILLING, BK_FULL, BK_DRAINING} bank_state_e;

  // Top-level state, visible hierarchically as fsm_state for checkers
  run_state_e    state_q, state_d;
  run_state_e    fsm_state;
  bank_state_e   bank_q [2];
  bank_state_e   bank_d [2];
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic          overflow_q, overflow_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic          dout_valid_q, dout_valid_d;
  logic          ep_ready_q, ep_ready_d;
  logic          done_q, done_d;

  logic          wr_fire, rd_fire, drop, fill_done, drain_done, start_clear;

  logic [WIDTH-1:0] mem [0:2*DEPTH-1];

  assign fsm_state   = state_q;
  assign start_clear = (state_q == ST_IDLE) && START;

  // Next-state logic: read side, write side, run FSM, then bank hand-over
  always_comb begin
    state_d      = state_q;
    bank_d[0]    = bank_q[0];
    bank_d[1]    = bank_q[1];
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    frame_cnt_d  = frame_cnt_q;
    overflow_d   = overflow_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    wr_fire      = 1'b0;
    drop         = 1'b0;
    fill_done    = 1'b0;
    drain_done   = 1'b0;
    rd_fire      = EP_READ && ep_ready_q;

    // The bank under BANK_SEL is always the oldest unread full bank
    if (rd_fire) begin
      dout_d       = mem[{rd_bank_q, rd_ptr_q}];
      dout_valid_d = 1'b1;
      rd_ptr_d     = rd_ptr_q + 1'b1;
      if (rd_ptr_q == AW'(DEPTH - 1)) drain_done = 1'b1;
      else                            bank_d[rd_bank_q] = BK_DRAINING;
    end

    if (state_q == ST_RUN && DIN_VALID) begin
      if (bank_q[wr_bank_q] == BK_FILLING) begin
        wr_fire  = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (wr_ptr_q == AW'(DEPTH - 1)) fill_done = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end

    if (drop) overflow_d = 1'b1;

    // A completed fill hands the writer to the other bank even if that bank
    // is still busy; it then waits there until the bank drains.
    if (fill_done) begin
      if (frame_cnt_q != 16'hFFFF) frame_cnt_d = frame_cnt_q + 16'd1;
      bank_d[wr_bank_q] = BK_FULL;
      wr_bank_d         = ~wr_bank_q;
    end

    case (state_q)
      ST_IDLE:   if (START) state_d = ST_RUN;
      ST_RUN:    if (FRAMES != 0 && fill_done && int'(frame_cnt_d) == FRAMES)
                   state_d = ST_FINISH;
      ST_FINISH: if (START) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Only open a new bank for writing while the run continues
    if (fill_done && state_d == ST_RUN && bank_q[~wr_bank_q] == BK_EMPTY)
      bank_d[~wr_bank_q] = BK_FILLING;

    if (drain_done) begin
      bank_d[rd_bank_q] = (state_q == ST_RUN && state_d == ST_RUN &&
                           wr_bank_d == rd_bank_q) ? BK_FILLING : BK_EMPTY;
      rd_bank_d = ~rd_bank_q;
    end

    if (start_clear) begin
      bank_d[0]   = BK_FILLING;
      bank_d[1]   = BK_EMPTY;
      wr_bank_d   = 1'b0;
      rd_bank_d   = 1'b0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      frame_cnt_d = '0;
      overflow_d  = 1'b0;
    end

    ep_ready_d = (bank_d[0] == BK_FULL) || (bank_d[0] == BK_DRAINING) ||
                 (bank_d[1] == BK_FULL) || (bank_d[1] == BK_DRAINING);
    done_d     = (state_d == ST_FINISH) && (bank_d[0] == BK_EMPTY) &&
                 (bank_d[1] == BK_EMPTY);
  end

  // State and registered outputs
  always_ff @(posedge CLK or negedge RST_BAR) begin
    if (!RST_BAR) begin
      state_q      <= ST_IDLE;
      bank_q[0]    <= BK_EMPTY;
      bank_q[1]    <= BK_EMPTY;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      frame_cnt_q  <= '0;
      overflow_q   <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      ep_ready_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bank_q[0]    <= bank_d[0];
      bank_q[1]    <= bank_d[1];
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      frame_cnt_q  <= frame_cnt_d;
      overflow_q   <= overflow_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      ep_ready_q   <= ep_ready_d;
      done_q       <= done_d;
    end
  end

  // Bank storage; contents are not reset, only the bookkeeping is
  always_ff @(posedge CLK) begin
    if (wr_fire) mem[{wr_bank_q, wr_ptr_q}] <= DATA_IN;
  end

  assign DATA_OUT   = dout_q;
  assign DOUT_VALID = dout_valid_q;
  assign EP_READY   = ep_ready_q;
  assign BANK_SEL   = rd_bank_q;
  assign FRAME_CNT  = frame_cnt_q;
  assign OVERFLOW   = overflow_q;
  assign DONE       = done_q;

`ifdef PP_OVF_CNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  // Saturating count of dropped words
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (drop && ovf_cnt_q != 16'hFFFF) ovf_cnt_d = ovf_cnt_q + 16'd1;
    if (start_clear) ovf_cnt_d = '0;
  end

  // Dropped-word counter register
  always_ff @(posedge CLK or negedge RST_BAR) begin
    if (!RST_BAR) ovf_cnt_q <= '0;
    else          ovf_cnt_q <= ovf_cnt_d;
  end

  assign OVF_COUNT = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_pingpong_xfer_buffer.sv
// Bench for pingpong_xfer_buffer with DEPTH=4: one instance with FRAMES=2
// (finite run) and one with FRAMES=0 (continuous), sharing all inputs.
module tb_pingpong_xfer_buffer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         ep_read = 1'b0;

  logic [W-1:0] f2_dout, f0_dout;
  logic         f2_dv, f0_dv, f2_rdy, f0_rdy, f2_sel, f0_sel;
  logic [15:0]  f2_fc, f0_fc;
  logic         f2_ovf, f0_ovf, f2_done, f0_done;
`ifdef PP_OVF_CNT_EN
  logic [15:0]  f2_ovfc, f0_ovfc;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  pingpong_xfer_buffer #(.WIDTH(W), .DEPTH(4), .FRAMES(2)) u_f2 (
    .CLK(clk), .RST_BAR(rst_n), .START(start), .DATA_IN(din),
    .DIN_VALID(din_valid), .EP_READ(ep_read), .DATA_OUT(f2_dout),
    .DOUT_VALID(f2_dv), .EP_READY(f2_rdy), .BANK_SEL(f2_sel),
    .FRAME_CNT(f2_fc), .OVERFLOW(f2_ovf), .DONE(f2_done)
`ifdef PP_OVF_CNT_EN
    , .OVF_COUNT(f2_ovfc)
`endif
  );

  pingpong_xfer_buffer #(.WIDTH(W), .DEPTH(4), .FRAMES(0)) u_f0 (
    .CLK(clk), .RST_BAR(rst_n), .START(start), .DATA_IN(din),
    .DIN_VALID(din_valid), .EP_READ(ep_read), .DATA_OUT(f0_dout),
    .DOUT_VALID(f0_dv), .EP_READY(f0_rdy), .BANK_SEL(f0_sel),
    .FRAME_CNT(f0_fc), .OVERFLOW(f0_ovf), .DONE(f0_done)
`ifdef PP_OVF_CNT_EN
    , .OVF_COUNT(f0_ovfc)
`endif
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog expected=finish actual=timeout");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic         start;
    logic         din_valid;
    logic [W-1:0] din;
    logic         ep_read;
    logic         dv;
    logic [W-1:0] dout;
    logic         rdy;
    logic         sel;
    logic [15:0]  fc;
    logic         ovf;
    logic         done;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t vt(input logic s, input logic v, input logic [W-1:0] d,
                              input logic r, input logic e_dv, input logic [W-1:0] e_do,
                              input logic e_rdy, input logic e_sel, input logic [15:0] e_fc,
                              input logic e_ovf, input logic e_done);
    vec_t t;
    t.start = s; t.din_valid = v; t.din = d; t.ep_read = r;
    t.dv = e_dv; t.dout = e_do; t.rdy = e_rdy; t.sel = e_sel;
    t.fc = e_fc; t.ovf = e_ovf; t.done = e_done;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Driver: apply inputs at a falling edge, clock once, return at next falling edge
  task automatic step(input logic s, input logic v, input logic [W-1:0] d, input logic r);
    start = s; din_valid = v; din = d; ep_read = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; din_valid = 1'b0; ep_read = 1'b0; din = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_f0_reset(input string tag);
    chk({tag, "_dout"}, 32'(f0_dout), 32'h0);
    chk({tag, "_dv"},   32'(f0_dv),   32'h0);
    chk({tag, "_rdy"},  32'(f0_rdy),  32'h0);
    chk({tag, "_sel"},  32'(f0_sel),  32'h0);
    chk({tag, "_fc"},   32'(f0_fc),   32'h0);
    chk({tag, "_ovf"},  32'(f0_ovf),  32'h0);
    chk({tag, "_done"}, 32'(f0_done), 32'h0);
  endtask

  initial begin
    // Reset state of both instances
    #3;
    chk_f0_reset("rst0_f0");
    chk("rst0_f2_dv", 32'(f2_dv), 0);
    chk("rst0_f2_rdy", 32'(f2_rdy), 0);
    chk("rst0_f2_done", 32'(f2_done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Finite run, FRAMES=2: 8 writes, 8 reads, then restart from FINISH
    vecs[0]  = vt(1, 0, 16'd0,  0, 0, 16'd0, 0, 0, 16'd0, 0, 0);
    vecs[1]  = vt(0, 1, 16'd1,  0, 0, 16'd0, 0, 0, 16'd0, 0, 0);
    vecs[2]  = vt(0, 1, 16'd2,  0, 0, 16'd0, 0, 0, 16'd0, 0, 0);
    vecs[3]  = vt(0, 1, 16'd3,  0, 0, 16'd0, 0, 0, 16'd0, 0, 0);
    vecs[4]  = vt(0, 1, 16'd4,  0, 0, 16'd0, 1, 0, 16'd1, 0, 0);
    vecs[5]  = vt(0, 1, 16'd5,  0, 0, 16'd0, 1, 0, 16'd1, 0, 0);
    vecs[6]  = vt(0, 1, 16'd6,  0, 0, 16'd0, 1, 0, 16'd1, 0, 0);
    vecs[7]  = vt(0, 1, 16'd7,  0, 0, 16'd0, 1, 0, 16'd1, 0, 0);
    vecs[8]  = vt(0, 1, 16'd8,  0, 0, 16'd0, 1, 0, 16'd2, 0, 0);
    vecs[9]  = vt(0, 1, 16'd99, 1, 1, 16'd1, 1, 0, 16'd2, 0, 0);
    vecs[10] = vt(0, 0, 16'd0,  1, 1, 16'd2, 1, 0, 16'd2, 0, 0);
    vecs[11] = vt(0, 0, 16'd0,  1, 1, 16'd3, 1, 0, 16'd2, 0, 0);
    vecs[12] = vt(0, 0, 16'd0,  1, 1, 16'd4, 1, 1, 16'd2, 0, 0);
    vecs[13] = vt(0, 0, 16'd0,  1, 1, 16'd5, 1, 1, 16'd2, 0, 0);
    vecs[14] = vt(0, 0, 16'd0,  1, 1, 16'd6, 1, 1, 16'd2, 0, 0);
    vecs[15] = vt(0, 0, 16'd0,  1, 1, 16'd7, 1, 1, 16'd2, 0, 0);
    vecs[16] = vt(0, 0, 16'd0,  1, 1, 16'd8, 0, 0, 16'd2, 0, 1);
    vecs[17] = vt(0, 0, 16'd0,  1, 0, 16'd8, 0, 0, 16'd2, 0, 1);
    vecs[18] = vt(1, 0, 16'd0,  0, 0, 16'd8, 0, 0, 16'd2, 0, 0);
    vecs[19] = vt(0, 0, 16'd0,  1, 0, 16'd8, 0, 0, 16'd2, 0, 0);

    for (int i = 0; i < 20; i++) begin
      step(vecs[i].start, vecs[i].din_valid, vecs[i].din, vecs[i].ep_read);
      chk($sformatf("v%0d_dv", i),   32'(f2_dv),   32'(vecs[i].dv));
      chk($sformatf("v%0d_dout", i), 32'(f2_dout), 32'(vecs[i].dout));
      chk($sformatf("v%0d_rdy", i),  32'(f2_rdy),  32'(vecs[i].rdy));
      chk($sformatf("v%0d_sel", i),  32'(f2_sel),  32'(vecs[i].sel));
      chk($sformatf("v%0d_fc", i),   32'(f2_fc),   32'(vecs[i].fc));
      chk($sformatf("v%0d_ovf", i),  32'(f2_ovf),  32'(vecs[i].ovf));
      chk($sformatf("v%0d_done", i), 32'(f2_done), 32'(vecs[i].done));
    end

    // Continuous run, no reads: words 9..12 dropped, 1..8 retained in order
    do_reset();
    step(1, 0, 0, 0);
    for (int i = 1; i <= 12; i++) step(0, 1, 16'(i), 0);
    step(0, 0, 0, 0);
    chk("ovf_flag", 32'(f0_ovf), 1);
    chk("ovf_fc", 32'(f0_fc), 2);
    chk("ovf_rdy", 32'(f0_rdy), 1);
`ifdef PP_OVF_CNT_EN
    chk("ovf_count", 32'(f0_ovfc), 4);
`endif
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, 0, 1);
      chk($sformatf("ovf_rd%0d_dv", i), 32'(f0_dv), 1);
      chk($sformatf("ovf_rd%0d_dout", i), 32'(f0_dout), 32'(i));
    end
    step(0, 0, 0, 0);
    chk("ovf_end_rdy", 32'(f0_rdy), 0);
    chk("ovf_end_sticky", 32'(f0_ovf), 1);

    // Continuous streaming: one write and one read per cycle after bank 0 fills
    do_reset();
    exp_q.delete();
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(16'h100 + 16'(i));
      step(0, 1, 16'h100 + 16'(i), 0);
    end
    for (int k = 0; k < 20; k++) begin
      logic [W-1:0] exp_word;
      if (k < 16) begin
        exp_q.push_back(16'h104 + 16'(k));
        step(0, 1, 16'h104 + 16'(k), 1);
      end else begin
        step(0, 0, 0, 1);
      end
      exp_word = exp_q.pop_front();
      chk($sformatf("str%0d_dv", k), 32'(f0_dv), 1);
      chk($sformatf("str%0d_dout", k), 32'(f0_dout), 32'(exp_word));
      chk($sformatf("str%0d_sel", k), 32'(f0_sel), 32'(((k + 1) / 4) % 2));
    end
    step(0, 0, 0, 0);
    chk("str_ovf", 32'(f0_ovf), 0);
    chk("str_fc", 32'(f0_fc), 5);
    chk("str_rdy", 32'(f0_rdy), 0);
    chk("str_left", 32'(exp_q.size()), 0);

    // EP_READ held while nothing is ready is ignored; first real read gets word 0
    do_reset();
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1);
      chk($sformatf("idle_rd%0d_dv", i), 32'(f0_dv), 0);
      chk($sformatf("idle_rd%0d_rdy", i), 32'(f0_rdy), 0);
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 16'h300 + 16'(i), 1);
      chk($sformatf("fill_rd%0d_dv", i), 32'(f0_dv), 0);
    end
    chk("fill_rdy", 32'(f0_rdy), 1);
    step(0, 0, 0, 1);
    chk("first_rd_dv", 32'(f0_dv), 1);
    chk("first_rd_dout", 32'(f0_dout), 32'h300);

    // Reset mid-drain, then a fresh run returns the new data
    do_reset();
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 16'h400 + 16'(i), 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("pre_rst_dout", 32'(f0_dout), 32'h401);
    rst_n = 1'b0;
    ep_read = 1'b0;
    #1;
    chk_f0_reset("async_rst");
    @(posedge clk);
    @(negedge clk);
    chk_f0_reset("held_rst");
    rst_n = 1'b1;
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 16'h500 + 16'(i), 0);
    chk("post_rst_fc", 32'(f0_fc), 1);
    step(0, 0, 0, 1);
    chk("post_rst_dv", 32'(f0_dv), 1);
    chk("post_rst_dout", 32'(f0_dout), 32'h500);

    // Report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
